// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among
// NUM_PORTS requesters, with a watchdog that aborts unacked accesses.
module sdram_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_PORTS-1:0]            req_we_i,
  input  logic [NUM_PORTS-1:0]            req_re_i,
  output logic [DATA_WIDTH-1:0]           req_data_o,
  output logic [NUM_PORTS-1:0]            req_ack_o,
  output logic [NUM_PORTS-1:0]            req_err_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_data_o,
  output logic                            mem_we_o,
  output logic                            mem_re_o,
  input  logic [DATA_WIDTH-1:0]           mem_data_i,
  input  logic                            mem_ack_i,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_o,
  output logic                            busy_o
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [GW-1:0]     last_q;
  logic [WW-1:0]     wd_q;
  logic [NUM_PORTS-1:0] req;
  logic [GW-1:0]     win_d;
  logic [GW-1:0]     cand;
  logic              found;

  assign req = req_we_i | req_re_i;

  // Round-robin search starting just after the last granted port
  always_comb begin
    win_d = last_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = GW'((int'(last_q) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
  end

  // Arbitration FSM with registered strobes, acks and watchdog
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      last_q     <= LAST_RST;
      wd_q       <= '0;
      grant_o    <= '0;
      busy_o     <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_re_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
      req_data_o <= '0;
      req_ack_o  <= '0;
      req_err_o  <= '0;
    end else begin
      req_ack_o <= '0;
      req_err_o <= '0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            grant_o    <= win_d;
            last_q     <= win_d;
            mem_addr_o <= req_addr_i[win_d*ADDR_WIDTH +: ADDR_WIDTH];
            mem_data_o <= req_data_i[win_d*DATA_WIDTH +: DATA_WIDTH];
            mem_we_o   <= req_we_i[win_d];
            mem_re_o   <= ~req_we_i[win_d];
            wd_q       <= '0;
            busy_o     <= 1'b1;
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack_i) begin
            req_data_o         <= mem_data_i;
            mem_we_o           <= 1'b0;
            mem_re_o           <= 1'b0;
            req_ack_o[grant_o] <= 1'b1;
            state_q            <= S_RESP;
          end else if (wd_q == WD_MAX) begin
            req_data_o         <= '0;
            mem_we_o           <= 1'b0;
            mem_re_o           <= 1'b0;
            req_ack_o[grant_o] <= 1'b1;
            req_err_o[grant_o] <= 1'b1;
            state_q            <= S_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RESP: begin
          wd_q    <= '0;
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: random requesters, a
// behavioural controller, and a round-robin reference model.
module tb_sdram_port_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]  req_we_i = '0;
  logic [N-1:0]  req_re_i = '0;
  logic [DW-1:0] req_data_o;
  logic [N-1:0]  req_ack_o;
  logic [N-1:0]  req_err_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_we_o;
  logic          mem_re_o;
  logic [DW-1:0] mem_data_i = '0;
  logic          ctl_ack = 1'b0;
  logic          late_ack = 1'b0;
  logic          mem_ack_i;
  logic [$clog2(N)-1:0] grant_o;
  logic          busy_o;

  assign mem_ack_i = ctl_ack | late_ack;

  sdram_port_arbiter #(
    .NUM_PORTS(N), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_we_i(req_we_i), .req_re_i(req_re_i),
    .req_data_o(req_data_o), .req_ack_o(req_ack_o),
    .req_err_o(req_err_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .grant_o(grant_o),
    .busy_o(busy_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
    logic          re;
    int            lat;
  } txn_t;

  typedef struct {
    int   port;
    txn_t t;
  } mexp_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          cd;
    logic          err;
  } aexp_t;

  mexp_t mem_q[$];
  aexp_t ack_q[$];
  int    lat_q[$];
  txn_t  plist[N][$];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] ctl_mem[logic [AW-1:0]];
  int    last_g = N - 1;
  int    checks = 0;
  int    errors = 0;
  logic  rst_seen = 1'b1;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] dflt(logic [AW-1:0] a);
    return {16'hA5A5, a};
  endfunction

  always @(posedge sys_clk) rst_seen <= sys_rst;

  // Controller model: acks after lat strobe cycles, never when lat==0
  int c_act = 0;
  int c_cnt = 0;
  int c_lat = 0;
  always @(negedge sys_clk) begin
    ctl_ack    = 1'b0;
    mem_data_i = $urandom;
    if (rst_seen) begin
      c_act = 0;
    end else begin
      if (c_act == 0 && (mem_we_o || mem_re_o)) begin
        c_act = 1;
        c_cnt = 0;
        c_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      end
      if (c_act != 0) begin
        c_cnt++;
        if (!(mem_we_o || mem_re_o)) begin
          c_act = 0;
        end else if (c_lat != 0 && c_cnt == c_lat) begin
          ctl_ack = 1'b1;
          if (mem_we_o)
            ctl_mem[mem_addr_o] = mem_data_o;
          else
            mem_data_i = ctl_mem.exists(mem_addr_o) ?
                         ctl_mem[mem_addr_o] : dflt(mem_addr_o);
          c_act = 0;
        end
      end
    end
  end

  // Monitor: compares strobe transactions and acks with the scoreboard
  int    m_act = 0;
  int    m_dur = 0;
  mexp_t m_cur;
  aexp_t a_cur;
  always @(negedge sys_clk) begin
    if (rst_seen) begin
      m_act = 0;
    end else begin
      if ((mem_we_o || mem_re_o) && m_act == 0) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got addr %0h expected none",
                   mem_addr_o);
        end else begin
          m_cur = mem_q.pop_front();
          chk("grant", 64'(grant_o), 64'(m_cur.port));
          chk("mem_addr", 64'(mem_addr_o), 64'(m_cur.t.addr));
          chk("mem_we", 64'(mem_we_o), 64'(m_cur.t.we));
          chk("mem_re", 64'(mem_re_o), 64'(!m_cur.t.we));
          if (m_cur.t.we)
            chk("mem_data", 64'(mem_data_o), 64'(m_cur.t.data));
        end
        m_act = 1;
        m_dur = 1;
      end else if ((mem_we_o || mem_re_o) && m_act != 0) begin
        m_dur++;
      end else if (m_act != 0) begin
        chk("strobe_cycles", 64'(m_dur),
            64'((m_cur.t.lat == 0) ? TO : m_cur.t.lat));
        m_act = 0;
      end
      if (|req_ack_o) begin
        if (ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got %0b expected none", req_ack_o);
        end else begin
          a_cur = ack_q.pop_front();
          chk("ack_vec", 64'(req_ack_o), 64'(1) << a_cur.port);
          chk("err_vec", 64'(req_err_o),
              a_cur.err ? (64'(1) << a_cur.port) : 64'(0));
          if (a_cur.cd)
            chk("req_data", 64'(req_data_o), 64'(a_cur.data));
        end
      end else if (|req_err_o) begin
        checks++; errors++;
        $display("FAIL err_without_ack: got %0b expected 0", req_err_o);
      end
    end
  end

  task automatic drive(int p, txn_t t);
    req_addr_i[p*AW +: AW] = t.addr;
    req_data_i[p*DW +: DW] = t.data;
    req_we_i[p] = t.we;
    req_re_i[p] = t.re;
  endtask

  task automatic undrive(int p);
    req_we_i[p] = 1'b0;
    req_re_i[p] = 1'b0;
  endtask

  // Predict the grant order, push expectations, then play the requesters
  task automatic run_round(int wp, int budget);
    int idx[N];
    logic [N-1:0] pend;
    int total, p, cyc, wcnt;
    txn_t t;
    aexp_t a;
    total = 0;
    for (int q = 0; q < N; q++) begin
      idx[q] = 0;
      total += plist[q].size();
    end
    for (int k = 0; k < total; k++) begin
      p = -1;
      for (int i = 1; i <= N; i++) begin
        if (p < 0 && idx[(last_g + i) % N] < plist[(last_g + i) % N].size())
          p = (last_g + i) % N;
      end
      t = plist[p][idx[p]];
      idx[p]++;
      last_g = p;
      mem_q.push_back('{p, t});
      lat_q.push_back(t.lat);
      a.port = p;
      a.err  = (t.lat == 0);
      a.cd   = 1'b1;
      a.data = '0;
      if (t.lat != 0) begin
        if (t.we) begin
          ref_mem[t.addr] = t.data;
          a.cd = 1'b0;
        end else begin
          a.data = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
        end
      end
      ack_q.push_back(a);
    end
    pend = '0;
    for (int q = 0; q < N; q++) begin
      idx[q] = 0;
      if (plist[q].size() > 0) begin
        drive(q, plist[q][0]);
        pend[q] = 1'b1;
      end
    end
    cyc = 0;
    wcnt = 0;
    while (pend != 0 && cyc < budget) begin
      @(negedge sys_clk);
      cyc++;
      for (int q = 0; q < N; q++) begin
        if (pend[q] && req_ack_o[q]) begin
          idx[q]++;
          if (idx[q] < plist[q].size()) begin
            drive(q, plist[q][idx[q]]);
          end else begin
            undrive(q);
            pend[q] = 1'b0;
          end
        end
      end
      if (wp >= 0 && (mem_we_o || mem_re_o) && int'(grant_o) == wp &&
          pend[wp]) begin
        wcnt++;
        if (wcnt == 2) undrive(wp);
      end
    end
    chk("round_done", 64'(pend), 64'(0));
    for (int q = 0; q < N; q++) plist[q].delete();
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_grant"}, 64'(grant_o), 0);
    chk({tag, "_busy"}, 64'(busy_o), 0);
    chk({tag, "_we"}, 64'(mem_we_o), 0);
    chk({tag, "_re"}, 64'(mem_re_o), 0);
    chk({tag, "_ack"}, 64'(req_ack_o), 0);
    chk({tag, "_err"}, 64'(req_err_o), 0);
    chk({tag, "_addr"}, 64'(mem_addr_o), 0);
    chk({tag, "_mdata"}, 64'(mem_data_o), 0);
    chk({tag, "_rdata"}, 64'(req_data_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    txn_t t;
    int n, r, cyc;
    repeat (3) @(negedge sys_clk);
    chk_zero("reset");
    sys_rst = 1'b0;
    ref_mem[16'h0010] = 32'hDEADBEEF;
    ctl_mem[16'h0010] = 32'hDEADBEEF;
    @(negedge sys_clk);

    plist[0].push_back('{16'h0010, 32'h0, 1'b0, 1'b1, 5});
    run_round(-1, 100);

    for (int p = 0; p < N; p++)
      for (int k = 0; k < 3; k++)
        plist[p].push_back('{16'h0020 + 16'(k), $urandom, k[0], ~k[0],
                             int'($urandom_range(1, 4))});
    run_round(-1, 200);

    plist[1].push_back('{16'h0ABC, 32'h12345678, 1'b1, 1'b1, 3});
    run_round(-1, 100);

    plist[0].push_back('{16'h0030, 32'h0, 1'b0, 1'b1, 0});
    run_round(-1, 100);
    late_ack = 1'b1;
    @(negedge sys_clk);
    late_ack = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      chk("late_busy", 64'(busy_o), 0);
      chk("late_strobe", 64'(mem_we_o | mem_re_o), 0);
    end

    plist[1].push_back('{16'h0040, 32'h0, 1'b0, 1'b1, 6});
    run_round(1, 100);

    for (int rd = 0; rd < 25; rd++) begin
      for (int p = 0; p < N; p++) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) begin
          r = $urandom_range(0, 2);
          t.addr = 16'h0100 + 16'($urandom_range(0, 7));
          t.data = $urandom;
          t.we   = (r != 0);
          t.re   = (r != 1);
          t.lat  = ($urandom_range(0, 9) == 0 && !t.we) ? 0 :
                   int'($urandom_range(1, 6));
          plist[p].push_back(t);
        end
      end
      run_round(-1, 400);
    end

    t = '{16'h0050, 32'h0, 1'b0, 1'b1, 0};
    mem_q.push_back('{1, t});
    lat_q.push_back(0);
    ack_q.push_back('{1, 32'h0, 1'b1, 1'b1});
    drive(1, t);
    cyc = 0;
    while (!(mem_we_o || mem_re_o) && cyc < 20) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("rst_txn_started", 64'(mem_re_o), 1);
    repeat (2) @(negedge sys_clk);
    undrive(1);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    chk_zero("midrst");
    ack_q.delete();
    last_g = N - 1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("post_rst_noack", 64'(ack_q.size()), 0);
    plist[0].push_back('{16'h0060, 32'h0, 1'b0, 1'b1, 2});
    plist[1].push_back('{16'h0061, 32'h0, 1'b0, 1'b1, 2});
    run_round(-1, 100);

    chk("queues_drained", 64'(mem_q.size() + ack_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
